// File: rtl/penc_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : penc_rr_arb                                                       |
// | Desc   : Registered N-input arbiter, fixed-priority or round-robin, with   |
// |          the grant held under a valid/ack handshake.                       |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module penc_rr_arb #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] ptr
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [W-1:0] C_LAST = W'(N - 1);
  localparam logic [W:0]   C_N    = (W + 1)'(N);

  state_t         state_q, state_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [N-1:0]   gnt_onehot_q, gnt_onehot_d;
  logic [W-1:0]   ptr_q, ptr_d;

  logic           arb_now;
  logic [W-1:0]   fix_idx;
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [W-1:0]   rr_off;
  logic [W:0]     rr_sum;
  logic [W-1:0]   rr_idx;

  // Decide whether this edge arbitrates; an ack in round-robin mode moves the
  // pointer past the served requester before the same-edge re-arbitration.
  always_comb begin
    arb_now = 1'b0;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: arb_now = 1'b1;
      GRANT: begin
        if (ack) begin
          arb_now = 1'b1;
          if (mode) begin
            ptr_d = (gnt_idx_q == C_LAST) ? '0 : gnt_idx_q + W'(1);
          end
        end
      end
      default: arb_now = 1'b0;
    endcase
  end

  // Fixed priority: the highest set request index wins.
  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fix_idx = W'(i);
    end
  end

  // Round-robin: rotate req so bit 0 is the pointer position, take the lowest
  // set bit as an offset, then map the offset back modulo N.
  always_comb begin
    req_dbl = {req, req} >> ptr_d;
    req_rot = req_dbl[N-1:0];
    rr_off  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) rr_off = W'(i);
    end
    rr_sum = {1'b0, ptr_d} + {1'b0, rr_off};
    if (rr_sum >= C_N) rr_sum = rr_sum - C_N;
    rr_idx = rr_sum[W-1:0];
  end

  // Next-state and next-output logic; a live grant is frozen until acked.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    if (arb_now) begin
      if (en && (|req)) begin
        state_d      = GRANT;
        valid_d      = 1'b1;
        gnt_idx_d    = mode ? rr_idx : fix_idx;
        gnt_onehot_d = N'(1) << gnt_idx_d;
      end else begin
        state_d      = IDLE;
        valid_d      = 1'b0;
        gnt_idx_d    = '0;
        gnt_onehot_d = '0;
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      ptr_q        <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
      ptr_q        <= ptr_d;
    end
  end

  assign valid      = valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;
  assign ptr        = ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_penc_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_penc_rr_arb                                                    |
// | Desc   : Scoreboard bench for penc_rr_arb with directed stimulus.          |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_penc_rr_arb;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         en   = 1'b0;
  logic         mode = 1'b0;
  logic         ack  = 1'b0;
  logic [N-1:0] req  = '0;
  logic         valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;
  logic [W-1:0] ptr;

  typedef struct packed {
    logic [W-1:0] idx;
    logic [W-1:0] ptr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  penc_rr_arb #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .req        (req),
    .ack        (ack),
    .valid      (valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .ptr        (ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input int i, input int p);
    exp_t e;
    e.idx = W'(i);
    e.ptr = W'(p);
    exp_q.push_back(e);
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Highest set bit of a nonzero value.
  function automatic int hi_bit(input int v);
    return $clog2(v + 1) - 1;
  endfunction

  // Monitor: a fresh grant appears when valid rises or when the previous grant
  // was acked on this edge; each one is matched against the scoreboard.
  initial begin : monitor
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (valid && (!prev_valid || ack)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant: got idx %0d expected no grant at %0t", gnt_idx, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_idx", 32'(gnt_idx), 32'(e.idx));
          chk("sb_onehot", 32'(gnt_onehot), 32'(8'(1) << e.idx));
          chk("sb_ptr", 32'(ptr), 32'(e.ptr));
        end
      end
      prev_valid = valid;
    end
  end

  initial begin : stim
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_idx", 32'(gnt_idx), 0);
    chk("rst_onehot", 32'(gnt_onehot), 0);
    chk("rst_ptr", 32'(ptr), 0);
    rst = 1'b0;
    en  = 1'b1;
    req = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_noreq_valid", 32'(valid), 0);
    end

    // Fixed priority, every nonzero request pattern
    mode = 1'b0;
    for (int v = 1; v < 256; v++) begin
      req = 8'(v);
      push(hi_bit(v), 0);
      tick();
      chk("fix_latency_valid", 32'(valid), 1);
      if (v == 32'h26) begin
        chk("fix_0x26_idx", 32'(gnt_idx), 5);
        chk("fix_0x26_onehot", 32'(gnt_onehot), 32'h20);
      end
      req = '0;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("fix_release_valid", 32'(valid), 0);
    end

    // Round-robin fairness with all requesters active, acked every cycle
    mode = 1'b1;
    req  = 8'hFF;
    push(0, 0);
    tick();
    chk("rr_first_valid", 32'(valid), 1);
    for (int k = 1; k < 10; k++) begin
      ack = 1'b1;
      push(k % 8, k % 8);
      tick();
      chk("rr_nobubble_valid", 32'(valid), 1);
      chk("rr_ptr", 32'(ptr), 32'(k % 8));
    end
    req = '0;
    tick();
    ack = 1'b0;
    chk("rr_end_valid", 32'(valid), 0);
    chk("rr_end_ptr", 32'(ptr), 2);

    // Move the pointer to 6 by serving requester 5
    req = 8'h20;
    push(5, 2);
    tick();
    chk("rr_set_idx", 32'(gnt_idx), 5);
    req = '0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("rr_set_ptr", 32'(ptr), 6);
    chk("rr_set_valid", 32'(valid), 0);

    // Skip and wrap from ptr=6 over requests {0,2}
    req = 8'h05;
    push(0, 6);
    tick();
    chk("rr_wrap_idx", 32'(gnt_idx), 0);
    ack = 1'b1;
    push(2, 1);
    tick();
    chk("rr_skip_idx", 32'(gnt_idx), 2);
    chk("rr_skip_ptr", 32'(ptr), 1);
    req = '0;
    tick();
    ack = 1'b0;
    chk("rr_drop_valid", 32'(valid), 0);
    chk("rr_drop_ptr", 32'(ptr), 3);

    // Grant held while req, mode and en wander without ack
    mode = 1'b0;
    req  = 8'h08;
    push(3, 3);
    tick();
    chk("hold_grant_idx", 32'(gnt_idx), 3);
    for (int c = 0; c < 4; c++) begin
      req  = '0;
      mode = ~mode;
      en   = ~en;
      tick();
      chk("hold_idx", 32'(gnt_idx), 3);
      chk("hold_valid", 32'(valid), 1);
      chk("hold_onehot", 32'(gnt_onehot), 32'h08);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("hold_release_valid", 32'(valid), 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("spurious_ack_valid", 32'(valid), 0);
    chk("spurious_ack_ptr", 32'(ptr), 3);

    // Enable gating
    en  = 1'b0;
    req = 8'h10;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("en_off_valid", 32'(valid), 0);
    end
    en = 1'b1;
    push(4, 3);
    tick();
    chk("en_on_valid", 32'(valid), 1);
    chk("en_on_idx", 32'(gnt_idx), 4);
    en  = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("en_off_ack_valid", 32'(valid), 0);
    tick();
    chk("en_off_nogrant_valid", 32'(valid), 0);

    // Asynchronous reset in the middle of a grant
    en  = 1'b1;
    req = 8'h20;
    push(5, 3);
    tick();
    chk("midrst_pre_idx", 32'(gnt_idx), 5);
    chk("midrst_pre_valid", 32'(valid), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_idx", 32'(gnt_idx), 0);
    chk("midrst_onehot", 32'(gnt_onehot), 0);
    chk("midrst_ptr", 32'(ptr), 0);
    req = '0;
    #2 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("post_rst_idle_valid", 32'(valid), 0);
    end

    tick();
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
